// File: rtl/input_sweep_capture_pkg.sv
// Shared constants and FSM encoding for the input sweep/capture block.
// Minterm index convention: idx = 16*X + 8*Y + 4*Z + 2*K + M.
package input_sweep_capture_pkg;

  localparam int IDX_W = 5;
  localparam int TT_W  = 32;
  localparam int VAR_W = 5;

  localparam int X_BIT = 4;
  localparam int Y_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int K_BIT = 1;
  localparam int M_BIT = 0;

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/input_sweep_capture_if.sv
// Board/function-stage signal bundle: the master side drives switches,
// mode, start and the returned f_in; the slave side is the sweep block.
interface input_sweep_capture_if;
  import input_sweep_capture_pkg::*;

  logic [VAR_W-1:0] sw;
  logic             mode;
  logic             start;
  logic             f_in;
  logic             x;
  logic             y;
  logic             z;
  logic             k;
  logic             m;
  logic [TT_W-1:0]  truth_table;
  logic             busy;
  logic             done;

  modport master (
    output sw, mode, start, f_in,
    input  x, y, z, k, m, truth_table, busy, done
  );

  modport slave (
    input  sw, mode, start, f_in,
    output x, y, z, k, m, truth_table, busy, done
  );

endinterface

// File: rtl/input_sweep_capture_sw_debounce.sv
// Whole-vector switch debouncer: a changed vector is accepted only after
// it has been stable for DEBOUNCE_CYCLES consecutive samples.
module input_sweep_capture_sw_debounce #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] accepted_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path can infer a latch.
    prev_d = sw_i;
    acc_d  = acc_q;
    cnt_d  = '0;
    if (sw_i != acc_q && sw_i == prev_q) begin
      if (cnt_q == CNT_LAST) begin
        acc_d = sw_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign accepted_o = acc_q;

endmodule

// File: rtl/input_sweep_capture.sv
// Drives X..M to the external function stage, either from debounced switches
// or by sweeping all 32 minterms and capturing f_in into a truth table.
module input_sweep_capture
  import input_sweep_capture_pkg::*;
#(
  parameter int HOLD_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rst,
  input_sweep_capture_if.slave bus_if
);

  localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [HOLD_W-1:0] hold_q;
  logic [TT_W-1:0]   tt_q;
  logic [VAR_W-1:0]  vars_q;
  logic [VAR_W-1:0]  sw_acc;
  logic              busy_q;
  logic              done_q;

  input_sweep_capture_sw_debounce #(
    .WIDTH           (VAR_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .sw_i       (bus_if.sw),
    .accepted_o (sw_acc)
  );

  // Outputs, busy and done are registered from the FSM state, so they trail it by one edge.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every branch reads pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      tt_q    <= '0;
      vars_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!bus_if.mode) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      vars_q  <= sw_acc;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      if (state_q == ST_DRIVE || state_q == ST_SAMPLE) begin
        tt_q <= '0;
      end
    end else begin
      vars_q <= idx_q;
      busy_q <= (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
      done_q <= (state_q == ST_DONE);
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus_if.start) begin
            state_q <= ST_DRIVE;
            idx_q   <= '0;
            hold_q  <= '0;
            tt_q    <= '0;
          end
        end
        ST_DRIVE: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= ST_SAMPLE;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          tt_q[idx_q] <= bus_if.f_in;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ST_DRIVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_if.x           = vars_q[X_BIT];
  assign bus_if.y           = vars_q[Y_BIT];
  assign bus_if.z           = vars_q[Z_BIT];
  assign bus_if.k           = vars_q[K_BIT];
  assign bus_if.m           = vars_q[M_BIT];
  assign bus_if.truth_table = tt_q;
  assign bus_if.busy        = busy_q;
  assign bus_if.done        = done_q;

endmodule

// File: tb/tb_input_sweep_capture.sv
// Bench for input_sweep_capture: two instances (HOLD_CYCLES 4 and 1), a function-stage
// model on f_in, and per-instance scoreboards checked whenever done rises.
module tb_input_sweep_capture;
  import input_sweep_capture_pkg::*;

  localparam int HOLD_A = 4;
  localparam int HOLD_B = 1;
  localparam int DEB    = 16;
  localparam logic [4:0] SW_HOME = 5'b10110;

  typedef struct {
    logic [31:0] tt;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  input_sweep_capture_if bus_a ();
  input_sweep_capture_if bus_b ();

  input_sweep_capture #(.HOLD_CYCLES(HOLD_A), .DEBOUNCE_CYCLES(DEB)) dut_a (
    .clk(clk), .rst(rst), .bus_if(bus_a)
  );
  input_sweep_capture #(.HOLD_CYCLES(HOLD_B), .DEBOUNCE_CYCLES(DEB)) dut_b (
    .clk(clk), .rst(rst), .bus_if(bus_b)
  );

  logic [4:0]  va, vb;
  int          fsel_a, fsel_b;
  logic [31:0] rand_tt_a, rand_tt_b;
  exp_t        q_a[$];
  exp_t        q_b[$];

  assign va = {bus_a.x, bus_a.y, bus_a.z, bus_a.k, bus_a.m};
  assign vb = {bus_b.x, bus_b.y, bus_b.z, bus_b.k, bus_b.m};

  // Function stage: 0 = minterm list, 1 = constant 1, 2 = M, otherwise a random table.
  function automatic logic stage_f(input int fsel, input logic [31:0] tbl, input logic [4:0] v);
    int mins [16] = '{0, 2, 3, 4, 6, 8, 10, 11, 15, 17, 18, 19, 21, 23, 25, 27};
    logic r = 1'b0;
    case (fsel)
      0: for (int j = 0; j < 16; j++) if (mins[j] == int'(v)) r = 1'b1;
      1: r = 1'b1;
      2: r = v[0];
      default: r = tbl[v];
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_table(input int fsel, input logic [31:0] tbl);
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) r[i] = stage_f(fsel, tbl, 5'(i));
    return r;
  endfunction

  assign bus_a.f_in = stage_f(fsel_a, rand_tt_a, va);
  assign bus_b.f_in = stage_f(fsel_b, rand_tt_b, vb);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: pop the expected sweep result whenever done rises.
  logic done_a_prev = 1'b0;
  logic done_b_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.done && !done_a_prev) begin
      if (q_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_a: done rose with no sweep outstanding (cycle %0d)", cyc);
      end else begin
        e = q_a.pop_front();
        check("a truth_table", bus_a.truth_table, e.tt);
        check("a done cycle", cyc, e.done_cyc);
        check("a X..M at done", va, 5'b11111);
        check("a busy at done", bus_a.busy, 1'b0);
      end
    end
    done_a_prev <= bus_a.done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_b.done && !done_b_prev) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_b: done rose with no sweep outstanding (cycle %0d)", cyc);
      end else begin
        e = q_b.pop_front();
        check("b truth_table", bus_b.truth_table, e.tt);
        check("b done cycle", cyc, e.done_cyc);
        check("b X..M at done", vb, 5'b11111);
      end
    end
    done_b_prev <= bus_b.done;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; start is sampled at the next posedge (edge t = cyc+1).
  task automatic start_sweep(input bit sel_b, input bit expect_done, input logic [31:0] exp_tt);
    exp_t e;
    e.tt = exp_tt;
    if (sel_b) begin
      e.done_cyc = cyc + 2 + 32 * (HOLD_B + 1);
      bus_b.start = 1'b1;
      if (expect_done) q_b.push_back(e);
    end else begin
      e.done_cyc = cyc + 2 + 32 * (HOLD_A + 1);
      bus_a.start = 1'b1;
      if (expect_done) q_a.push_back(e);
    end
    tick(1);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic drain(input bit sel_b, input string name);
    int waited = 0;
    while (((sel_b ? q_b.size() : q_a.size()) != 0) && waited < 400) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check({name, " completed in time"}, sel_b ? q_b.size() : q_a.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] v, prev;
    int waited;
    rst = 1'b1;
    bus_a.sw = '0; bus_a.mode = 1'b0; bus_a.start = 1'b0;
    bus_b.sw = '0; bus_b.mode = 1'b0; bus_b.start = 1'b0;
    fsel_a = 0; fsel_b = 0; rand_tt_a = '0; rand_tt_b = '0;
    tick(3);
    check("reset X..M", va, 5'b00000);
    check("reset truth_table", bus_a.truth_table, 32'h0);
    check("reset busy", bus_a.busy, 1'b0);
    check("reset done", bus_a.done, 1'b0);
    rst = 1'b0;
    tick(2);

    // Manual debounce: stable change appears DEB+1 edges after the first sampling edge.
    bus_a.sw = SW_HOME;
    tick(DEB + 1);
    check("debounce before accept", va, 5'b00000);
    tick(1);
    check("debounce accepted", va, SW_HOME);
    for (int p = 0; p < 8; p++) begin
      bus_a.sw = (p % 2 == 0) ? 5'b01001 : SW_HOME;
      tick(5);
      check("toggle every 5 ignored", va, SW_HOME);
    end
    prev = bus_a.sw;
    for (int n = 0; n < 10; n++) begin
      v = prev ^ 5'($urandom_range(1, 31));
      bus_a.sw = v;
      tick($urandom_range(1, DEB - 4));
      check("short random burst ignored", va, SW_HOME);
      prev = v;
    end
    v = 5'($urandom);
    bus_a.sw = v;
    tick(DEB + 3);
    check("random stable value accepted", va, v);
    bus_a.sw = SW_HOME;
    tick(DEB + 3);
    check("home value accepted", va, SW_HOME);

    // Sweep mode on instance A.
    bus_a.mode = 1'b1;
    tick(2);
    check("sweep idle X..M", va, 5'b00000);
    check("sweep idle busy", bus_a.busy, 1'b0);
    fsel_a = 0;
    start_sweep(1'b0, 1'b1, ref_table(0, '0));
    tick(1);
    bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    check("busy during sweep", bus_a.busy, 1'b1);
    drain(1'b0, "minterm sweep");

    fsel_a = 1;
    tick(1);
    start_sweep(1'b0, 1'b1, ref_table(1, '0));
    drain(1'b0, "restart sweep f=1");

    rand_tt_a = $urandom;
    fsel_a = 3;
    tick($urandom_range(1, 6));
    start_sweep(1'b0, 1'b1, ref_table(3, rand_tt_a));
    drain(1'b0, "random table sweep a");

    // Abort by dropping mode while vector 12 is on the outputs.
    fsel_a = 0;
    start_sweep(1'b0, 1'b0, '0);
    waited = 0;
    while (va != 5'd12 && waited < 200) begin
      tick(1);
      waited++;
    end
    check("abort reached idx 12", va, 5'd12);
    bus_a.mode = 1'b0;
    tick(1);
    check("abort busy", bus_a.busy, 1'b0);
    check("abort done", bus_a.done, 1'b0);
    check("abort truth_table cleared", bus_a.truth_table, 32'h0);
    check("abort X..M follows switches", va, SW_HOME);
    bus_a.mode = 1'b1;
    tick(2);
    check("re-enter sweep idle X..M", va, 5'b00000);
    check("re-enter sweep idle busy", bus_a.busy, 1'b0);

    // Reset mid-sweep: full reset state, no resumption.
    fsel_a = 1;
    start_sweep(1'b0, 1'b0, '0);
    tick(30);
    check("busy before reset", bus_a.busy, 1'b1);
    rst = 1'b1;
    tick(1);
    check("mid reset X..M", va, 5'b00000);
    check("mid reset truth_table", bus_a.truth_table, 32'h0);
    check("mid reset busy", bus_a.busy, 1'b0);
    check("mid reset done", bus_a.done, 1'b0);
    rst = 1'b0;
    tick(20);
    check("not resumed busy", bus_a.busy, 1'b0);
    check("not resumed X..M", va, 5'b00000);

    // Instance B with HOLD_CYCLES = 1.
    bus_b.mode = 1'b1;
    fsel_b = 2;
    tick(2);
    start_sweep(1'b1, 1'b1, ref_table(2, '0));
    drain(1'b1, "hold1 f=M sweep");
    for (int r = 0; r < 3; r++) begin
      rand_tt_b = $urandom;
      fsel_b = 3;
      tick($urandom_range(1, 5));
      start_sweep(1'b1, 1'b1, ref_table(3, rand_tt_b));
      drain(1'b1, "hold1 random sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
